// File: rtl/tl45_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tl45_rf_write_arbiter
//   Shares the single register-file write port between the in-order
//   writeback path (A) and the long-latency return path (B: divider / load
//   return).
//
//   Arbitration:
//     - A has priority.
//     - B is protected by a starvation counter. After B has waited STARVE_MAX
//       cycles, A is stalled and B is forced through.
//
//   Scoreboard:
//     A 16-entry scoreboard marks registers that still have an outstanding
//     B write, so decode can detect the hazard and stall.
//
//   Parameters:
//     STARVE_MAX   cycles B may wait before A is stalled (>= 1)
//
//   Optional feature:
//     TL45_WBARB_FWD_EN adds o_fwd_reg / o_fwd_val. These are registered
//     alongside the write port so decode can bypass the value in the cycle
//     the register file is written.
//
//   Ports:
//     i_clk, i_reset_n              clock / async active-low reset
//     i_a_dr, i_a_val               writeback dest reg (0 = none) and data
//     o_pipe_stall                  stall to writeback (A held upstream)
//     i_b_valid, i_b_dr, i_b_val    long-latency result
//     o_b_ready                     B accepted this cycle (combinational)
//     i_sb_set, i_sb_reg            mark register pending at issue
//     i_chk_reg, o_chk_busy         decode hazard query (combinational)
//     o_rf_en, o_rf_reg, o_rf_val   registered register-file write port
// -----------------------------------------------------------------------------
module tl45_rf_write_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_a_dr,
    input  logic [31:0] i_a_val,
    output logic        o_pipe_stall,
    input  logic        i_b_valid,
    input  logic [3:0]  i_b_dr,
    input  logic [31:0] i_b_val,
    output logic        o_b_ready,
    input  logic        i_sb_set,
    input  logic [3:0]  i_sb_reg,
    input  logic [3:0]  i_chk_reg,
    output logic        o_chk_busy,
`ifdef TL45_WBARB_FWD_EN
    output logic [3:0]  o_fwd_reg,
    output logic [31:0] o_fwd_val,
`endif
    output logic        o_rf_en,
    output logic [3:0]  o_rf_reg,
    output logic [31:0] o_rf_val
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

    typedef enum logic {NORMAL, FORCE_B} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] sb_q, sb_d;
    logic        rf_en_q, rf_en_d;
    logic [3:0]  rf_reg_q, rf_reg_d;
    logic [31:0] rf_val_q, rf_val_d;
    logic        a_req, grant_b;

    always_comb begin
        a_req   = (i_a_dr != 4'd0);
        grant_b = (state_q == FORCE_B) ? i_b_valid : (i_b_valid & ~a_req);

        // Counts consecutive cycles B is left waiting; any gap or accept restarts it.
        cnt_d = cnt_q;
        if (!i_b_valid || grant_b) cnt_d = '0;
        else if (cnt_q != CMAX)    cnt_d = cnt_q + 1'b1;

        // Force B once its wait reaches the limit. The stall then shows up on
        // the very next cycle, so B sees exactly STARVE_MAX refused cycles.
        // FORCE_B always lasts one cycle: either B is accepted, or B dropped
        // valid and there is nothing left to force.
        state_d = NORMAL;
        if (state_q == NORMAL && cnt_d == CMAX) state_d = FORCE_B;

        // Apply the clear before the set, so a new issue to the same register
        // wins over the returning result.
        sb_d = sb_q;
        if (grant_b)                         sb_d[i_b_dr]   = 1'b0;
        if (i_sb_set && i_sb_reg != 4'd0)    sb_d[i_sb_reg] = 1'b1;
        sb_d[0] = 1'b0;

        rf_en_d  = 1'b0;
        rf_reg_d = 4'd0;
        rf_val_d = 32'd0;
        if (grant_b) begin
            rf_en_d  = (i_b_dr != 4'd0);
            rf_reg_d = i_b_dr;
            rf_val_d = i_b_val;
        end else if (state_q == NORMAL && a_req) begin
            rf_en_d  = 1'b1;
            rf_reg_d = i_a_dr;
            rf_val_d = i_a_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= NORMAL;
            cnt_q    <= '0;
            sb_q     <= 16'd0;
            rf_en_q  <= 1'b0;
            rf_reg_q <= 4'd0;
            rf_val_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sb_q     <= sb_d;
            rf_en_q  <= rf_en_d;
            rf_reg_q <= rf_reg_d;
            rf_val_q <= rf_val_d;
        end
    end

`ifdef TL45_WBARB_FWD_EN
    logic [3:0]  fwd_reg_q;
    logic [31:0] fwd_val_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fwd_reg_q <= 4'd0;
            fwd_val_q <= 32'd0;
        end else begin
            fwd_reg_q <= rf_en_d ? rf_reg_d : 4'd0;
            fwd_val_q <= rf_val_d;
        end
    end

    assign o_fwd_reg = fwd_reg_q;
    assign o_fwd_val = fwd_val_q;
`endif

    // The grant is gated with reset so a pending B is never acknowledged while
    // reset is held; the B unit re-presents its result after release.
    assign o_b_ready    = grant_b & i_reset_n;
    assign o_pipe_stall = (state_q == FORCE_B);
    assign o_chk_busy   = sb_q[i_chk_reg];
    assign o_rf_en      = rf_en_q;
    assign o_rf_reg     = rf_reg_q;
    assign o_rf_val     = rf_val_q;

endmodule

// File: tb/tb_tl45_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tl45_rf_write_arbiter (STARVE_MAX = 4).
//
// Stimulus is applied in three parts:
//   - Directed vectors from a table.
//   - Hand-written sequences for starvation and mid-force reset.
//   - Randomized cycles checked against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_tl45_rf_write_arbiter;

    localparam int SMAX = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [3:0]  i_a_dr;
    logic [31:0] i_a_val;
    logic        o_pipe_stall;
    logic        i_b_valid;
    logic [3:0]  i_b_dr;
    logic [31:0] i_b_val;
    logic        o_b_ready;
    logic        i_sb_set;
    logic [3:0]  i_sb_reg;
    logic [3:0]  i_chk_reg;
    logic        o_chk_busy;
    logic        o_rf_en;
    logic [3:0]  o_rf_reg;
    logic [31:0] o_rf_val;
`ifdef TL45_WBARB_FWD_EN
    logic [3:0]  o_fwd_reg;
    logic [31:0] o_fwd_val;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    tl45_rf_write_arbiter #(.STARVE_MAX(SMAX)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_a_dr(i_a_dr), .i_a_val(i_a_val), .o_pipe_stall(o_pipe_stall),
        .i_b_valid(i_b_valid), .i_b_dr(i_b_dr), .i_b_val(i_b_val), .o_b_ready(o_b_ready),
        .i_sb_set(i_sb_set), .i_sb_reg(i_sb_reg), .i_chk_reg(i_chk_reg), .o_chk_busy(o_chk_busy),
`ifdef TL45_WBARB_FWD_EN
        .o_fwd_reg(o_fwd_reg), .o_fwd_val(o_fwd_val),
`endif
        .o_rf_en(o_rf_en), .o_rf_reg(o_rf_reg), .o_rf_val(o_rf_val)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs already driven.
    // Checks the combinational outputs at the following negedge, then the
    // registered write port just after the next posedge.
    task automatic run_cycle(input string tag, input logic e_rdy, input logic e_stall,
                             input logic e_busy, input logic e_en, input logic [3:0] e_reg,
                             input logic [31:0] e_val);
        @(negedge i_clk);
        check({tag, ".ready"}, 32'(o_b_ready), 32'(e_rdy));
        check({tag, ".stall"}, 32'(o_pipe_stall), 32'(e_stall));
        check({tag, ".busy"},  32'(o_chk_busy), 32'(e_busy));
        @(posedge i_clk);
        #1;
        check({tag, ".rf_en"},  32'(o_rf_en), 32'(e_en));
        check({tag, ".rf_reg"}, 32'(o_rf_reg), 32'(e_reg));
        check({tag, ".rf_val"}, o_rf_val, e_val);
`ifdef TL45_WBARB_FWD_EN
        check({tag, ".fwd_reg"}, 32'(o_fwd_reg), e_en ? 32'(e_reg) : 32'd0);
        check({tag, ".fwd_val"}, o_fwd_val, e_val);
`endif
    endtask

    task automatic drive(input logic [3:0] adr, input logic [31:0] aval, input logic bv,
                         input logic [3:0] bdr, input logic [31:0] bval, input logic sset,
                         input logic [3:0] sreg, input logic [3:0] chk);
        i_a_dr = adr;  i_a_val = aval;
        i_b_valid = bv; i_b_dr = bdr; i_b_val = bval;
        i_sb_set = sset; i_sb_reg = sreg; i_chk_reg = chk;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        drive(4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  a_dr;
        logic [31:0] a_val;
        logic        b_valid;
        logic [3:0]  b_dr;
        logic [31:0] b_val;
        logic        sb_set;
        logic [3:0]  sb_reg;
        logic [3:0]  chk;
        logic        e_rdy;
        logic        e_busy;
        logic        e_en;
        logic [3:0]  e_reg;
        logic [31:0] e_val;
    } vec_t;

    vec_t tbl[7];

    // Reference model state.
    bit          m_stall;
    int          m_wait;
    bit [15:0]   m_sb;

    initial begin
        // Directed vectors. Rows run back to back from reset, so the
        // scoreboard carries over from one row to the next.
        tbl[0] = '{4'd3, 32'h1234, 1'b0, 4'd0, 32'd0,      1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1, 4'd3, 32'h1234};
        tbl[1] = '{4'd0, 32'h0,    1'b1, 4'd5, 32'hCAFE,   1'b0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 32'hCAFE};
        tbl[2] = '{4'd0, 32'h0,    1'b0, 4'd0, 32'd0,      1'b1, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[3] = '{4'd0, 32'h0,    1'b1, 4'd7, 32'h77,     1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 4'd7, 32'h77};
        tbl[4] = '{4'd0, 32'h0,    1'b1, 4'd0, 32'h99,     1'b1, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 32'h99};
        tbl[5] = '{4'd9, 32'hAA,   1'b1, 4'd2, 32'h22,     1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 32'hAA};
        tbl[6] = '{4'd0, 32'h0,    1'b0, 4'd0, 32'd0,      1'b0, 4'd0, 4'd7, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0};

        do_reset();
        check("reset.rf_en",  32'(o_rf_en), 32'd0);
        check("reset.rf_val", o_rf_val, 32'd0);
        check("reset.stall",  32'(o_pipe_stall), 32'd0);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].a_dr, tbl[i].a_val, tbl[i].b_valid, tbl[i].b_dr, tbl[i].b_val,
                  tbl[i].sb_set, tbl[i].sb_reg, tbl[i].chk);
            run_cycle($sformatf("vec%0d", i), tbl[i].e_rdy, 1'b0, tbl[i].e_busy,
                      tbl[i].e_en, tbl[i].e_reg, tbl[i].e_val);
        end

        // Starvation: A busy every cycle while B waits.
        // B is refused for SMAX cycles; then A is stalled and B goes through.
        // A is written again once the stall drops.
        drive(4'd4, 32'h4444, 1'b1, 4'd6, 32'h6666, 1'b0, 4'd0, 4'd7);
        for (int k = 0; k < SMAX; k++)
            run_cycle($sformatf("starve%0d", k), 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h4444);
        run_cycle("force", 1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 32'h6666);
        i_b_valid = 1'b0;
        run_cycle("a_after", 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h4444);

        // Reset asserted mid-FORCE_B, between clock edges.
        i_b_valid = 1'b1;
        for (int k = 0; k < SMAX; k++)
            run_cycle($sformatf("restarve%0d", k), 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 32'h4444);
        #2;
        check("preRst.stall", 32'(o_pipe_stall), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("rst.stall", 32'(o_pipe_stall), 32'd0);
        check("rst.ready", 32'(o_b_ready), 32'd0);
        check("rst.rf_en", 32'(o_rf_en), 32'd0);
        check("rst.busy",  32'(o_chk_busy), 32'd0);
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        drive(4'd0, 32'd0, 1'b1, 4'd6, 32'h600D, 1'b0, 4'd0, 4'd7);
        run_cycle("postRst", 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 32'h600D);

        // Randomized run against the reference model.
        do_reset();
        m_stall = 0; m_wait = 0; m_sb = '0;
        drive(4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        for (int c = 0; c < 3000; c++) begin
            logic        rdy, hs, e_en;
            logic [3:0]  e_reg;
            logic [31:0] e_val;
            // Upstream holds A stable while the stall is visible.
            if (!m_stall) begin
                i_a_dr  = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
                i_a_val = $urandom;
            end
            i_b_valid = ($urandom_range(0, 9) < 6);
            i_b_dr    = 4'($urandom_range(0, 15));
            i_b_val   = $urandom;
            i_sb_set  = ($urandom_range(0, 9) < 4);
            i_sb_reg  = 4'($urandom_range(0, 15));
            i_chk_reg = 4'($urandom_range(0, 15));

            rdy = m_stall ? i_b_valid : (i_b_valid && i_a_dr == 0);
            hs  = i_b_valid && rdy;
            if (hs) begin
                e_en = (i_b_dr != 0); e_reg = i_b_dr; e_val = i_b_val;
            end else if (!m_stall && i_a_dr != 0) begin
                e_en = 1'b1; e_reg = i_a_dr; e_val = i_a_val;
            end else begin
                e_en = 1'b0; e_reg = 4'd0; e_val = 32'd0;
            end

            run_cycle("rand", rdy, m_stall, m_sb[i_chk_reg], e_en, e_reg, e_val);

            if (hs) m_sb[i_b_dr] = 1'b0;
            if (i_sb_set && i_sb_reg != 0) m_sb[i_sb_reg] = 1'b1;
            if (!i_b_valid || hs) m_wait = 0;
            else if (m_wait < SMAX) m_wait++;
            m_stall = (m_wait == SMAX);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
